// File: rtl/io_intr_controller_if.sv
// Bus bundle between the IO/interrupt controller and the CPU-side logic.
// The slave modport is the controller's view; master is the CPU/bench view.
interface io_intr_controller_if #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4
);
  localparam int VW = $clog2(NCH);

  logic [WIDTH-1:0] In;
  logic             InStrobe;
  logic             RdEn;
  logic [WIDTH-1:0] RdData;
  logic             InEmpty;
  logic             InFull;
  logic             InOverflow;
  logic             WrEn;
  logic [WIDTH-1:0] WrData;
  logic [WIDTH-1:0] Out;
  logic [NCH-1:0]   Int;
  logic             MaskWe;
  logic [NCH-1:0]   MaskData;
  logic             IntReq;
  logic [VW-1:0]    IntVec;
  logic             IntAck;
  logic             IntDone;

  modport slave (
    input  In, InStrobe, RdEn, WrEn, WrData, Int, MaskWe, MaskData, IntAck, IntDone,
    output RdData, InEmpty, InFull, InOverflow, Out, IntReq, IntVec
  );

  modport master (
    output In, InStrobe, RdEn, WrEn, WrData, Int, MaskWe, MaskData, IntAck, IntDone,
    input  RdData, InEmpty, InFull, InOverflow, Out, IntReq, IntVec
  );
endinterface

// File: rtl/io_intr_controller.sv
// IO controller: show-ahead input FIFO, registered output port and a
// non-nesting, lowest-index-first interrupt controller with edge capture.
module io_intr_controller #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int NCH   = 4
) (
  input logic                 Clk,
  input logic                 Rst,
  io_intr_controller_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int VW = $clog2(NCH);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             overflow;
  logic             empty, full, push, pop;
  logic [WIDTH-1:0] out_reg;

  logic [NCH-1:0]   int_prev, pending, mask;
  logic [NCH-1:0]   edges, req_bits, ack_clr;
  logic [VW-1:0]    vec, vec_next, lowest;
  state_t           state, state_next;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign pop   = bus.RdEn && !empty;
  // A pop in the same cycle frees the slot, so a push while full is still taken
  assign push  = bus.InStrobe && (!full || pop);

  always_ff @(posedge Clk) begin
    if (push)
      mem[wr_ptr] <= bus.In;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.InStrobe && full && !bus.RdEn)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      out_reg <= '0;
    else if (bus.WrEn)
      out_reg <= bus.WrData;
  end

  assign bus.RdData     = empty ? '0 : mem[rd_ptr];
  assign bus.InEmpty    = empty;
  assign bus.InFull     = full;
  assign bus.InOverflow = overflow;
  assign bus.Out        = out_reg;

  // int_prev resets low so a line already high at reset release counts as an edge
  assign edges    = bus.Int & ~int_prev;
  assign req_bits = pending & mask;

  always_comb begin
    lowest = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req_bits[i])
        lowest = VW'(i);
    end
  end

  always_comb begin
    state_next = state;
    vec_next   = vec;
    ack_clr    = '0;
    case (state)
      IDLE: begin
        if (|req_bits) begin
          state_next = REQ;
          vec_next   = lowest;
        end
      end
      REQ: begin
        if (bus.IntAck) begin
          state_next = SERVICE;
          ack_clr    = NCH'(1) << vec;
        end
      end
      SERVICE: begin
        if (bus.IntDone)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= IDLE;
      vec      <= '0;
      int_prev <= '0;
      pending  <= '0;
      mask     <= '1;
    end else begin
      state    <= state_next;
      vec      <= vec_next;
      int_prev <= bus.Int;
      // A fresh edge on the acknowledged channel wins over the clear
      pending  <= (pending & ~ack_clr) | edges;
      if (bus.MaskWe)
        mask <= bus.MaskData;
    end
  end

  assign bus.IntReq = (state == REQ);
  assign bus.IntVec = vec;
endmodule

// File: tb/tb_io_intr_controller.sv
// Directed bench for io_intr_controller with a queue-based reference model
// compared against the DUT on every falling edge.
module tb_io_intr_controller;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int NCH   = 4;

  logic Clk;
  logic Rst;
  int   passCount = 0;
  int   checkCount = 0;

  io_intr_controller_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

  io_intr_controller #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NCH(NCH)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: FIFO as a queue, interrupt controller as request/service flags
  logic [WIDTH-1:0] mq[$];
  bit               mOverflow;
  logic [WIDTH-1:0] mOut;
  logic [NCH-1:0]   mPrev, mPend, mMask;
  bit               mReq, mSvc;
  int               mVec;

  always @(posedge Clk or posedge Rst) begin
    bit             popOk, pushOk;
    logic [NCH-1:0] edges, nextPend;
    if (Rst) begin
      mq.delete();
      mOverflow = 0;
      mOut      = '0;
      mPrev     = '0;
      mPend     = '0;
      mMask     = '1;
      mReq      = 0;
      mSvc      = 0;
      mVec      = 0;
    end else begin
      popOk  = bus.RdEn && (mq.size() > 0);
      pushOk = bus.InStrobe && ((mq.size() < DEPTH) || popOk);
      if (bus.InStrobe && (mq.size() == DEPTH) && !bus.RdEn)
        mOverflow = 1;
      if (popOk)
        void'(mq.pop_front());
      if (pushOk)
        mq.push_back(bus.In);
      if (bus.WrEn)
        mOut = bus.WrData;
      edges    = bus.Int & ~mPrev;
      nextPend = mPend | edges;
      if (mReq) begin
        if (bus.IntAck) begin
          nextPend[mVec] = edges[mVec];
          mReq = 0;
          mSvc = 1;
        end
      end else if (mSvc) begin
        if (bus.IntDone)
          mSvc = 0;
      end else if ((mPend & mMask) != 0) begin
        mReq = 1;
        for (int i = 0; i < NCH; i++) begin
          if (mPend[i] && mMask[i]) begin
            mVec = i;
            break;
          end
        end
      end
      if (bus.MaskWe)
        mMask = bus.MaskData;
      mPrev = bus.Int;
      mPend = nextPend;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp)
      passCount++;
    else
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge Clk) begin
    checkOutput("m_RdData", 32'(bus.RdData), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
    checkOutput("m_InEmpty", 32'(bus.InEmpty), 32'(mq.size() == 0));
    checkOutput("m_InFull", 32'(bus.InFull), 32'(mq.size() == DEPTH));
    checkOutput("m_InOverflow", 32'(bus.InOverflow), 32'(mOverflow));
    checkOutput("m_Out", 32'(bus.Out), 32'(mOut));
    checkOutput("m_IntReq", 32'(bus.IntReq), 32'(mReq));
    if (mReq)
      checkOutput("m_IntVec", 32'(bus.IntVec), 32'(mVec));
  end

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic resetPulse();
    Rst = 1'b1;
    applyStimulus(1);
    Rst = 1'b0;
    applyStimulus(1);
  endtask

  task automatic fillFifo();
    logic [WIDTH-1:0] vals [4];
    vals = '{16'h0005, 16'h0019, 16'hFFFF, 16'hF320};
    for (int i = 0; i < 4; i++) begin
      bus.In = vals[i];
      bus.InStrobe = 1'b1;
      applyStimulus(1);
    end
    bus.InStrobe = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] expSeq [4];
    expSeq = '{16'h0005, 16'h0019, 16'hFFFF, 16'hF320};
    Rst = 1'b1;
    bus.In = '0; bus.InStrobe = 0; bus.RdEn = 0; bus.WrEn = 0; bus.WrData = '0;
    bus.Int = '0; bus.MaskWe = 0; bus.MaskData = '0; bus.IntAck = 0; bus.IntDone = 0;
    applyStimulus(3);
    checkOutput("rst_RdData", 32'(bus.RdData), 32'h0);
    checkOutput("rst_InEmpty", 32'(bus.InEmpty), 32'h1);
    checkOutput("rst_InFull", 32'(bus.InFull), 32'h0);
    checkOutput("rst_IntReq", 32'(bus.IntReq), 32'h0);
    checkOutput("rst_Out", 32'(bus.Out), 32'h0);
    Rst = 1'b0;
    applyStimulus(1);

    fillFifo();
    checkOutput("fill_InFull", 32'(bus.InFull), 32'h1);
    checkOutput("fill_head", 32'(bus.RdData), 32'h0005);
    checkOutput("fill_noOvf", 32'(bus.InOverflow), 32'h0);
    bus.In = 16'h1111; bus.InStrobe = 1'b1;
    applyStimulus(1);
    bus.InStrobe = 1'b0;
    checkOutput("ovf_set", 32'(bus.InOverflow), 32'h1);
    checkOutput("ovf_head", 32'(bus.RdData), 32'h0005);
    for (int i = 0; i < 4; i++) begin
      checkOutput("pop_data", 32'(bus.RdData), 32'(expSeq[i]));
      bus.RdEn = 1'b1;
      applyStimulus(1);
      bus.RdEn = 1'b0;
    end
    checkOutput("drain_InEmpty", 32'(bus.InEmpty), 32'h1);
    checkOutput("drain_RdData", 32'(bus.RdData), 32'h0);
    bus.RdEn = 1'b1;
    applyStimulus(1);
    bus.RdEn = 1'b0;
    checkOutput("popEmpty_InEmpty", 32'(bus.InEmpty), 32'h1);
    checkOutput("ovf_sticky", 32'(bus.InOverflow), 32'h1);

    resetPulse();
    checkOutput("rst_ovfClear", 32'(bus.InOverflow), 32'h0);
    fillFifo();
    bus.In = 16'hBEEF; bus.InStrobe = 1'b1; bus.RdEn = 1'b1;
    applyStimulus(1);
    bus.InStrobe = 1'b0; bus.RdEn = 1'b0;
    checkOutput("fullPP_InFull", 32'(bus.InFull), 32'h1);
    checkOutput("fullPP_head", 32'(bus.RdData), 32'h0019);
    checkOutput("fullPP_noOvf", 32'(bus.InOverflow), 32'h0);

    resetPulse();
    bus.In = 16'h7777; bus.InStrobe = 1'b1; bus.RdEn = 1'b1;
    applyStimulus(1);
    bus.InStrobe = 1'b0; bus.RdEn = 1'b0;
    checkOutput("emptyPP_head", 32'(bus.RdData), 32'h7777);
    checkOutput("emptyPP_InEmpty", 32'(bus.InEmpty), 32'h0);
    bus.RdEn = 1'b1;
    applyStimulus(1);
    bus.RdEn = 1'b0;

    bus.WrEn = 1'b1; bus.WrData = 16'hA5A5;
    applyStimulus(1);
    bus.WrEn = 1'b0; bus.WrData = 16'h1234;
    checkOutput("out_load", 32'(bus.Out), 32'hA5A5);
    applyStimulus(2);
    checkOutput("out_hold", 32'(bus.Out), 32'hA5A5);

    bus.Int = 4'b1010;
    applyStimulus(1);
    bus.Int = 4'b0000;
    applyStimulus(1);
    checkOutput("prio_IntReq", 32'(bus.IntReq), 32'h1);
    checkOutput("prio_IntVec1", 32'(bus.IntVec), 32'h1);
    bus.IntAck = 1'b1;
    applyStimulus(1);
    bus.IntAck = 1'b0;
    checkOutput("svc_IntReq", 32'(bus.IntReq), 32'h0);
    applyStimulus(2);
    checkOutput("svc_noNest", 32'(bus.IntReq), 32'h0);
    bus.IntDone = 1'b1;
    applyStimulus(1);
    bus.IntDone = 1'b0;
    applyStimulus(1);
    checkOutput("prio_IntReq2", 32'(bus.IntReq), 32'h1);
    checkOutput("prio_IntVec3", 32'(bus.IntVec), 32'h3);
    bus.IntAck = 1'b1;
    applyStimulus(1);
    bus.IntAck = 1'b0; bus.IntDone = 1'b1;
    applyStimulus(1);
    bus.IntDone = 1'b0;
    applyStimulus(2);
    checkOutput("prio_idle", 32'(bus.IntReq), 32'h0);

    bus.MaskWe = 1'b1; bus.MaskData = 4'b1110;
    applyStimulus(1);
    bus.MaskWe = 1'b0; bus.Int = 4'b0001;
    applyStimulus(1);
    bus.Int = 4'b0000;
    applyStimulus(3);
    checkOutput("mask_block", 32'(bus.IntReq), 32'h0);
    bus.MaskWe = 1'b1; bus.MaskData = 4'b1111;
    applyStimulus(1);
    bus.MaskWe = 1'b0;
    applyStimulus(1);
    checkOutput("mask_IntReq", 32'(bus.IntReq), 32'h1);
    checkOutput("mask_IntVec0", 32'(bus.IntVec), 32'h0);

    bus.IntAck = 1'b1;
    applyStimulus(1);
    bus.IntAck = 1'b0; bus.Int = 4'b0100;
    bus.In = 16'h1234; bus.InStrobe = 1'b1;
    bus.WrEn = 1'b1; bus.WrData = 16'h5555;
    applyStimulus(1);
    bus.Int = 4'b0000; bus.InStrobe = 1'b0; bus.WrEn = 1'b0;
    applyStimulus(1);
    checkOutput("svc_pendHeld", 32'(bus.IntReq), 32'h0);
    checkOutput("svc_fifo", 32'(bus.InEmpty), 32'h0);
    checkOutput("svc_out", 32'(bus.Out), 32'h5555);
    Rst = 1'b1;
    #1;
    checkOutput("rstSvc_IntReq", 32'(bus.IntReq), 32'h0);
    checkOutput("rstSvc_InEmpty", 32'(bus.InEmpty), 32'h1);
    checkOutput("rstSvc_Out", 32'(bus.Out), 32'h0);
    checkOutput("rstSvc_RdData", 32'(bus.RdData), 32'h0);
    applyStimulus(1);
    Rst = 1'b0;
    applyStimulus(4);
    checkOutput("rstSvc_pendClear", 32'(bus.IntReq), 32'h0);

    Rst = 1'b1; bus.Int = 4'b0100;
    applyStimulus(1);
    Rst = 1'b0;
    applyStimulus(2);
    checkOutput("relEdge_IntReq", 32'(bus.IntReq), 32'h1);
    checkOutput("relEdge_IntVec2", 32'(bus.IntVec), 32'h2);
    bus.IntAck = 1'b1;
    applyStimulus(1);
    bus.IntAck = 1'b0;
    applyStimulus(2);
    checkOutput("relEdge_levelNoRetrig", 32'(bus.IntReq), 32'h0);

    applyStimulus(1);
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
